// File: rtl/devilwalk2_sprite_fetch.sv
// rtl/devilwalk2_sprite_fetch.sv - devilwalk2 sprite hit test, ROM address and walk-cycle animation
//
// Purpose: per VGA pixel, tests the draw coordinate against the sprite box and
// forms the sprite ROM address for the current walk frame (mirrored when facing
// left). It also emits the palette index and the pixel_on flag two cycles after
// the draw coordinate.
//
// Ports:
//   clk_i          pixel/system clock
//   reset_i        synchronous active-high reset
//   frame_start_i  one-cycle pulse at start of vertical blank
//   walking_i      1 = character moving (animate)
//   facing_left_i  1 = mirror sprite horizontally
//   sprite_x_i/y_i sprite top-left corner, latched on frame_start_i
//   draw_x_i/y_i   current VGA pixel coordinate
//   rom_addr_o     sprite ROM address (ROM has 1-cycle read latency)
//   rom_data_i     ROM output for the previous rom_addr_o
//   pal_index_o    palette index (0 when not covered)
//   pixel_on_o     sprite covers pixel and index is opaque
module devilwalk2_sprite_fetch #(
  parameter int SPR_W           = 32,
  parameter int SPR_H           = 32,
  parameter int NUM_FRAMES      = 4,
  parameter int TICKS_PER_FRAME = 8,
  parameter int ADDR_W          = 12
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              frame_start_i,
  input  logic              walking_i,
  input  logic              facing_left_i,
  input  logic [9:0]        sprite_x_i,
  input  logic [9:0]        sprite_y_i,
  input  logic [9:0]        draw_x_i,
  input  logic [9:0]        draw_y_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [3:0]        rom_data_i,
  output logic [3:0]        pal_index_o,
  output logic              pixel_on_o
);

  localparam int TICK_W  = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
  localparam int FRAME_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

  typedef enum logic {
    ST_STAND,
    ST_WALK
  } state_t;

  state_t              state_q, state_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic                step;

  // Shadow copies of the sprite placement, only updated on frame_start_i.
  logic [9:0]          pos_x_q, pos_y_q;
  logic                facing_q;

  logic [ADDR_W-1:0]   rom_addr_q;
  logic                hit_s1_q, hit_s2_q;

  logic [10:0]         dx, dy, col;
  logic                hit;
  logic [ADDR_W-1:0]   addr_nxt;

  // Walk-cycle FSM. The pulse that enters WALK already counts as a tick.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    frame_d = frame_q;
    step    = 1'b0;
    case (state_q)
      ST_STAND: begin
        tick_d  = '0;
        frame_d = '0;
        if (frame_start_i && walking_i) begin
          state_d = ST_WALK;
          step    = 1'b1;
        end
      end
      ST_WALK: begin
        if (frame_start_i) begin
          if (walking_i) begin
            step = 1'b1;
          end else begin
            state_d = ST_STAND;
            tick_d  = '0;
            frame_d = '0;
          end
        end
      end
      default: state_d = ST_STAND;
    endcase
    if (step) begin
      if (tick_q == TICK_W'(TICKS_PER_FRAME - 1)) begin
        tick_d  = '0;
        frame_d = (frame_q == FRAME_W'(NUM_FRAMES - 1)) ? '0 : frame_q + 1'b1;
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end
  end

  // Stage 1 combinational part. The 11-bit differences are only meaningful
  // once the unsigned >= compares have ruled out a negative offset.
  always_comb begin
    dx       = {1'b0, draw_x_i} - {1'b0, pos_x_q};
    dy       = {1'b0, draw_y_i} - {1'b0, pos_y_q};
    hit      = (draw_x_i >= pos_x_q) && (draw_y_i >= pos_y_q) &&
               (dx < 11'(SPR_W)) && (dy < 11'(SPR_H));
    col      = facing_q ? (11'(SPR_W - 1) - dx) : dx;
    addr_nxt = ADDR_W'(frame_q) * ADDR_W'(SPR_W * SPR_H) +
               ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(col);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_STAND;
      tick_q     <= '0;
      frame_q    <= '0;
      pos_x_q    <= '0;
      pos_y_q    <= '0;
      facing_q   <= 1'b0;
      rom_addr_q <= '0;
      hit_s1_q   <= 1'b0;
      hit_s2_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      frame_q <= frame_d;
      if (frame_start_i) begin
        pos_x_q  <= sprite_x_i;
        pos_y_q  <= sprite_y_i;
        facing_q <= facing_left_i;
      end
      rom_addr_q <= hit ? addr_nxt : '0;
      hit_s1_q   <= hit;
      // Aligns the hit flag with rom_data_i, which lags rom_addr_o by one cycle.
      hit_s2_q   <= hit_s1_q;
    end
  end

  assign rom_addr_o  = rom_addr_q;
  assign pal_index_o = hit_s2_q ? rom_data_i : 4'd0;
  assign pixel_on_o  = hit_s2_q && (rom_data_i != 4'd0);

endmodule

// File: doc/devilwalk2_sprite_fetch.md
Name: devilwalk2_sprite_fetch

Overview:
- Upstream feeder for the devilwalk2 palette lookup.
- Per VGA pixel: hit-tests the draw coordinate against the sprite box and computes the sprite ROM address for the current walk-animation frame, mirrored when facing left.
- Emits the 4-bit palette index plus a pixel_on flag, 2 cycles after the draw coordinate.
- Owns the walk-cycle state machine; sprite position and direction are latched once per video frame.

Parameters:
- SPR_W, 32, sprite width in pixels (power of 2)
- SPR_H, 32, sprite height in pixels
- NUM_FRAMES, 4, walk-cycle animation frames stored back-to-back in ROM
- TICKS_PER_FRAME, 8, frame_start pulses per animation step
- ADDR_W, 12, ROM address width; must be ≥ clog2(NUM_FRAMES*SPR_W*SPR_H)

Ports:
- Clk  in  1  pixel/system clock
- Reset  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse at start of vertical blank
- walking  in  1  1 = character moving (animate), 0 = standing
- facing_left  in  1  1 = mirror sprite horizontally
- sprite_x  in  10  left edge of sprite, screen pixels
- sprite_y  in  10  top edge of sprite, screen pixels
- draw_x  in  10  current VGA pixel column
- draw_y  in  10  current VGA pixel row
- rom_addr  out  ADDR_W  address to synchronous sprite ROM (1-cycle read latency)
- rom_data  in  4  ROM output, valid the cycle after rom_addr
- pal_index  out  4  palette index to devilwalk2 palette
- pixel_on  out  1  1 = sprite covers this pixel and index is opaque

Behaviour:
- Reset (sync, Clk edge with Reset=1): pal_index=0, pixel_on=0, rom_addr=0, all pipeline valid bits 0, tick counter 0, anim frame 0, FSM=STAND, latched pos=0, latched facing=0. Reset wins over every other input in the same cycle.
- Latching: on frame_start, capture sprite_x, sprite_y, facing_left into shadow registers; hit test and address use only the shadow copies, so no mid-frame tearing.
- FSM:
  - STAND: anim frame forced to 0, tick counter held at 0.
  - STAND→WALK on frame_start with walking=1.
  - WALK: each frame_start increments the tick counter. At TICKS_PER_FRAME-1 the counter wraps to 0 and anim frame advances, wrapping NUM_FRAMES-1→0.
  - WALK→STAND on frame_start with walking=0: anim frame and counter cleared in that same cycle.
  - walking changes between frame_start pulses are ignored.
- Stage 1 (registered at cycle N+1 from draw coords at N):
  - dx = draw_x − pos_x, dy = draw_y − pos_y, computed in 11 bits.
  - hit = draw_x ≥ pos_x and draw_y ≥ pos_y and dx < SPR_W and dy < SPR_H. Compare unsigned and widened so pos near 1023 does not wrap.
  - col = facing ? SPR_W−1−dx : dx.
  - rom_addr = frame*SPR_W*SPR_H + dy*SPR_W + col, truncated to ADDR_W. rom_addr is 0 when not hit.
- Stage 2 (cycle N+2): pal_index = rom_data when hit_d1 else 0; pixel_on = hit_d1 and rom_data≠0 (index 0 transparent).
- Latency is exactly 2 cycles, fully pipelined, one pixel per cycle, no stalls.
- frame_start coinciding with an in-flight pixel: pixels already in stage 1 keep their old address. New shadow values apply from the next draw coordinate.
- Anim frame is sampled in stage 1 and may change only on frame_start.

Test Plan:
- Reset mid-stream with pixel_on=1 → next cycle pal_index=0, pixel_on=0, rom_addr=0; frame 0, STAND.
- pos=(100,50), facing=0, frame 0, draw=(100,50) → rom_addr=0 at N+1; rom_data=5 → pal_index=5, pixel_on=1 at N+2. draw=(131,81) → addr 1023. draw=(132,50) → pixel_on=0.
- facing_left=1, pos=(100,50), draw=(100,51) → rom_addr=32+31=63.
- walking=1, 8 frame_starts → anim frame 1, so draw=(100,50) gives rom_addr=1024. After 32 pulses frame wraps to 0. walking=0 at next pulse → frame 0 immediately.
- rom_data=0 inside box → pal_index=0, pixel_on=0. Change sprite_x mid-frame without frame_start → addresses unchanged until the pulse.
- pos=(1010,0), draw=(5,0) → no hit (no wrap); draw=(1023,0) → hit, addr 13.
